// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam logic [31:0] PIPE_RST_VAL = 32'h0000_0000;
    localparam int unsigned LANE_MAX_W   = 64;
    localparam int unsigned BUS_MAX_W    = 1024;

    // Lane idx of a lane-packed bus, lane 0 in the LSBs.
    function automatic logic [LANE_MAX_W-1:0] get_lane(input logic [BUS_MAX_W-1:0] bus,
                                                       input int unsigned idx,
                                                       input int unsigned lane_w);
        logic [BUS_MAX_W-1:0] shifted;
        shifted = bus >> (idx * lane_w);
        return shifted[LANE_MAX_W-1:0] & ((LANE_MAX_W'(1) << lane_w) - LANE_MAX_W'(1));
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready/data handshake bundle; master drives valid and data, slave drives ready.
interface pipe_stage_elastic_if #(
    parameter int unsigned W = 64
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_ctrl.sv
// Occupancy FSM for the elastic stage: handshake outputs and head/skid load enables.
module pipe_skid_ctrl
    import pipe_pkg::*;
#(
    parameter bit SKID_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       out_ready,
    input  logic       hold,
    input  logic       flush,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] occupancy,
    output logic       load_head,
    output logic       head_from_skid,
    output logic       load_skid,
    output logic       clear
);

    pipe_state_t state_q, state_d;
    logic        xfer_in, xfer_out;

    // With the skid, ready depends only on registered state; without it, ready passes out_ready through.
    assign out_valid = (state_q != EMPTY) & ~hold;
    assign in_ready  = rst & ~hold & (SKID_EN ? (state_q != TWO) : (~out_valid | out_ready));
    assign occupancy = state_q;
    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = out_valid & out_ready;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) state_q <= EMPTY;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (!hold) begin
            unique case (state_q)
                EMPTY: if (xfer_in) state_d = ONE;
                ONE: begin
                    if (xfer_in && !xfer_out)      state_d = SKID_EN ? TWO : ONE;
                    else if (!xfer_in && xfer_out) state_d = EMPTY;
                end
                TWO:     if (xfer_out) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        load_head      = 1'b0;
        head_from_skid = 1'b0;
        load_skid      = 1'b0;
        clear          = flush;
        if (!flush) begin
            unique case (state_q)
                EMPTY: load_head = xfer_in;
                ONE: begin
                    load_head = xfer_in & xfer_out;
                    load_skid = xfer_in & ~xfer_out & SKID_EN;
                end
                TWO: begin
                    load_head      = xfer_out;
                    head_from_skid = xfer_out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: NUM_FIELDS lanes with valid/ready, hazard hold,
// branch flush and an optional second (skid) entry.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       NUM_FIELDS = 2,
    parameter bit                SKID_EN    = 1'b1,
    parameter logic [DATA_W-1:0] RST_VAL    = DATA_W'(PIPE_RST_VAL),
    parameter int unsigned       CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_elastic_if.slave  up,
    pipe_stage_elastic_if.master dn,
    input  logic                 hold,
    input  logic                 flush,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int unsigned      BUS_W   = NUM_FIELDS * DATA_W;
    localparam logic [BUS_W-1:0] RST_BUS = {NUM_FIELDS{RST_VAL}};

    logic             in_ready, out_valid;
    logic             load_head, head_from_skid, load_skid, clear;
    logic [BUS_W-1:0] head_q, head_d, skid_q;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    pipe_skid_ctrl #(.SKID_EN(SKID_EN)) u_ctrl (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (up.valid),
        .out_ready      (dn.ready),
        .hold           (hold),
        .flush          (flush),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .occupancy      (occupancy),
        .load_head      (load_head),
        .head_from_skid (head_from_skid),
        .load_skid      (load_skid),
        .clear          (clear)
    );

    assign up.ready  = in_ready;
    assign dn.valid  = out_valid;
    assign dn.data   = head_q;
    assign flush_cnt = flush_cnt_q;

    always_comb begin
        head_d = head_q;
        if (clear)          head_d = RST_BUS;
        else if (load_head) head_d = head_from_skid ? skid_q : up.data;
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) head_q <= RST_BUS;
        else      head_q <= head_d;
    end

    generate
        if (SKID_EN) begin : g_skid
            logic [BUS_W-1:0] skid_d;
            always_comb begin
                skid_d = skid_q;
                if (clear)          skid_d = RST_BUS;
                else if (load_skid) skid_d = up.data;
            end
            always_ff @(negedge clk or negedge rst) begin
                if (!rst) skid_q <= RST_BUS;
                else      skid_q <= skid_d;
            end
        end else begin : g_no_skid
            logic unused_load_skid;
            assign unused_load_skid = load_skid;
            assign skid_q           = RST_BUS;
        end
    endgenerate

    // Counter saturates at all-ones so a long flush storm never wraps back to small values.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) flush_cnt_q <= '0;
        else      flush_cnt_q <= flush_cnt_d;
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: skid and non-skid builds driven in lockstep against queue models.
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned NF = 2;
    localparam int unsigned BW = DW * NF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hold = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic [1:0]    occ1, occ0;
    logic [7:0]    cnt1, cnt0;

    pipe_stage_elastic_if #(.W(BW)) up1 ();
    pipe_stage_elastic_if #(.W(BW)) dn1 ();
    pipe_stage_elastic_if #(.W(BW)) up0 ();
    pipe_stage_elastic_if #(.W(BW)) dn0 ();

    assign up1.valid = in_valid;
    assign up1.data  = in_data;
    assign dn1.ready = out_ready;
    assign up0.valid = in_valid;
    assign up0.data  = in_data;
    assign dn0.ready = out_ready;

    pipe_stage_elastic #(.DATA_W(DW), .NUM_FIELDS(NF), .SKID_EN(1'b1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .up(up1), .dn(dn1), .hold(hold), .flush(flush),
        .occupancy(occ1), .flush_cnt(cnt1));

    pipe_stage_elastic #(.DATA_W(DW), .NUM_FIELDS(NF), .SKID_EN(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .up(up0), .dn(dn0), .hold(hold), .flush(flush),
        .occupancy(occ0), .flush_cnt(cnt0));

    always #5 clk = ~clk;

    // Reference model: FIFO contents of each stage plus the last value left in the head register.
    logic [BW-1:0] q1[$], q0[$], del1[$];
    logic [BW-1:0] h1 = '0, h0 = '0;
    int            m_cnt = 0;
    int            errors = 0, checks = 0;

    logic          a_ir1, a_ov1, a_ir0, a_ov0, e_ir1, e_ov1, e_ir0, e_ov0;
    logic [BW-1:0] a_od1, a_od0, e_od1, e_od0;
    logic          p_ov1, p_ov0, x_ov1, x_ov0;
    logic [BW-1:0] p_od1, p_od0, x_od1, x_od0;
    logic [1:0]    p_occ1, p_occ0;
    logic [7:0]    p_cnt1, p_cnt0;
    int            x_occ1, x_occ0, x_cnt;

    task automatic model_reset();
        q1.delete(); q0.delete();
        h1 = '0; h0 = '0; m_cnt = 0;
    endtask

    // One negedge: drive, sample pre-edge outputs, advance the model, sample post-edge outputs.
    task automatic tick(input logic iv, input logic [BW-1:0] d, input logic ordy,
                        input logic hd, input logic fl);
        logic [BW-1:0] v;
        in_valid = iv; in_data = d; out_ready = ordy; hold = hd; flush = fl;
        #1;
        e_ir1 = (q1.size() < 2) && !hd;
        e_ov1 = (q1.size() > 0) && !hd;
        e_od1 = (q1.size() > 0) ? q1[0] : h1;
        e_ir0 = ((q0.size() == 0) || ordy) && !hd;
        e_ov0 = (q0.size() > 0) && !hd;
        e_od0 = (q0.size() > 0) ? q0[0] : h0;
        a_ir1 = up1.ready; a_ov1 = dn1.valid; a_od1 = dn1.data;
        a_ir0 = up0.ready; a_ov0 = dn0.valid; a_od0 = dn0.data;
        @(negedge clk);
        if (fl) begin
            q1.delete(); q0.delete(); h1 = '0; h0 = '0;
            if (m_cnt < 255) m_cnt++;
        end else if (!hd) begin
            if (e_ov1 && ordy) begin v = q1.pop_front(); del1.push_back(v); h1 = v; end
            if (iv && e_ir1) q1.push_back(d);
            if (q1.size() > 0) h1 = q1[0];
            if (e_ov0 && ordy) begin v = q0.pop_front(); h0 = v; end
            if (iv && e_ir0) q0.push_back(d);
            if (q0.size() > 0) h0 = q0[0];
        end
        #1;
        x_ov1 = (q1.size() > 0) && !hd; x_od1 = (q1.size() > 0) ? q1[0] : h1; x_occ1 = q1.size();
        x_ov0 = (q0.size() > 0) && !hd; x_od0 = (q0.size() > 0) ? q0[0] : h0; x_occ0 = q0.size();
        x_cnt = m_cnt;
        p_ov1 = dn1.valid; p_od1 = dn1.data; p_occ1 = occ1; p_cnt1 = cnt1;
        p_ov0 = dn0.valid; p_od0 = dn0.data; p_occ0 = occ0; p_cnt0 = cnt0;
    endtask

    task automatic drain();
        repeat (3) tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [BW-1:0] d;
        d = {32'hDEAD_BEEF, 32'h0040_0004};
        rst = 1'b0; in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (dn1.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", dn1.valid); end
        checks++; if (dn1.data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", dn1.data); end
        checks++; if (occ1 !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occ1); end
        checks++; if (cnt1 !== 8'd0) begin errors++; $display("FAIL reset_flush_cnt: got %0d want 0", cnt1); end
        checks++; if (up1.ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", up1.ready); end
        checks++; if (up0.ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_noskid: got %b want 0", up0.ready); end
        rst = 1'b1;
        model_reset();
        tick(1'b1, d, 1'b0, 1'b0, 1'b0);
        checks++; if (a_ir1 !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", a_ir1); end
        checks++; if (p_ov1 !== 1'b1) begin errors++; $display("FAIL first_beat_valid: got %b want 1", p_ov1); end
        checks++; if (p_od1 !== d) begin errors++; $display("FAIL first_beat_data: got %h want %h", p_od1, d); end
        checks++; if (p_occ1 !== 2'd1) begin errors++; $display("FAIL first_beat_occ: got %0d want 1", p_occ1); end
    endtask

    task automatic test_streaming();
        logic [BW-1:0]        d, sent[$];
        logic [BUS_MAX_W-1:0] wide;
        logic [DW-1:0]        pc, lane;
        drain(); del1.delete();
        for (int k = 0; k < 8; k++) begin
            pc = 32'h0040_0000 + DW'(4 * k);
            d  = {$urandom(), pc};
            sent.push_back(d);
            tick(1'b1, d, 1'b1, 1'b0, 1'b0);
            wide = BUS_MAX_W'(p_od1);
            lane = DW'(get_lane(wide, 0, DW));
            checks++; if (a_ir1 !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", k, a_ir1); end
            checks++; if (p_ov1 !== 1'b1 || p_od1 !== d) begin errors++; $display("FAIL stream_latency[%0d]: got v=%b %h want v=1 %h", k, p_ov1, p_od1, d); end
            checks++; if (lane !== pc) begin errors++; $display("FAIL stream_pc_lane[%0d]: got %h want %h", k, lane, pc); end
            checks++; if (a_ir0 !== 1'b1 || p_od0 !== d) begin errors++; $display("FAIL stream_noskid[%0d]: got r=%b %h want r=1 %h", k, a_ir0, p_od0, d); end
        end
        drain();
        checks++; if (del1.size() != 8) begin errors++; $display("FAIL stream_count: got %0d want 8", del1.size()); end
        for (int k = 0; k < 8 && k < del1.size(); k++) begin
            checks++; if (del1[k] !== sent[k]) begin errors++; $display("FAIL stream_order[%0d]: got %h want %h", k, del1[k], sent[k]); end
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] a, b, c;
        bit            c_taken;
        int            n;
        a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()}; c = {$urandom(), $urandom()};
        drain(); del1.delete();
        tick(1'b1, a, 1'b0, 1'b0, 1'b0);
        tick(1'b1, b, 1'b0, 1'b0, 1'b0);
        checks++; if (p_occ1 !== 2'd2) begin errors++; $display("FAIL bp_occ_two: got %0d want 2", p_occ1); end
        tick(1'b1, c, 1'b0, 1'b0, 1'b0);
        checks++; if (a_ir1 !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", a_ir1); end
        checks++; if (p_occ1 !== 2'd2 || p_od1 !== a) begin errors++; $display("FAIL bp_head: got occ=%0d %h want occ=2 %h", p_occ1, p_od1, a); end
        c_taken = 1'b0; n = 0;
        while (del1.size() < 3 && n < 10) begin
            tick(!c_taken, c, 1'b1, 1'b0, 1'b0);
            if (!c_taken && e_ir1) c_taken = 1'b1;
            checks++; if (a_ov1 !== e_ov1 || a_od1 !== e_od1) begin errors++; $display("FAIL bp_drain_head: got v=%b %h want v=%b %h", a_ov1, a_od1, e_ov1, e_od1); end
            n++;
        end
        checks++; if (del1.size() != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", del1.size()); end
        if (del1.size() == 3) begin
            checks++; if (del1[0] !== a || del1[1] !== b || del1[2] !== c) begin errors++; $display("FAIL bp_order: got %h %h %h want %h %h %h", del1[0], del1[1], del1[2], a, b, c); end
        end
    endtask

    task automatic test_hold();
        logic [BW-1:0] hv;
        hv = BW'(32'h1111);
        drain();
        tick(1'b1, hv, 1'b0, 1'b0, 1'b0);
        checks++; if (p_occ1 !== 2'd1) begin errors++; $display("FAIL hold_setup_occ: got %0d want 1", p_occ1); end
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, BW'(32'h2222), k[0] == 1'b0, 1'b1, 1'b0);
            checks++; if (a_ov1 !== 1'b0 || a_ir1 !== 1'b0) begin errors++; $display("FAIL hold_masked[%0d]: got v=%b r=%b want 0 0", k, a_ov1, a_ir1); end
            checks++; if (a_ir0 !== 1'b0) begin errors++; $display("FAIL hold_noskid_ready[%0d]: got %b want 0", k, a_ir0); end
            checks++; if (p_occ1 !== 2'd1) begin errors++; $display("FAIL hold_occ[%0d]: got %0d want 1", k, p_occ1); end
        end
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (a_ov1 !== 1'b1 || a_od1 !== hv) begin errors++; $display("FAIL hold_release: got v=%b %h want v=1 %h", a_ov1, a_od1, hv); end
    endtask

    task automatic test_noskid();
        logic [BW-1:0] a, b;
        a = {$urandom(), $urandom()}; b = {$urandom(), $urandom()};
        drain();
        tick(1'b1, a, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = b; out_ready = 1'b0; #1;
        checks++; if (up0.ready !== 1'b0) begin errors++; $display("FAIL noskid_ready_low: got %b want 0", up0.ready); end
        checks++; if (up1.ready !== 1'b1) begin errors++; $display("FAIL skid_ready_registered: got %b want 1", up1.ready); end
        out_ready = 1'b1; #1;
        checks++; if (up0.ready !== 1'b1) begin errors++; $display("FAIL noskid_ready_comb: got %b want 1", up0.ready); end
        tick(1'b1, b, 1'b1, 1'b0, 1'b0);
        checks++; if (p_od0 !== b || p_occ0 !== 2'd1) begin errors++; $display("FAIL noskid_replace: got occ=%0d %h want occ=1 %h", p_occ0, p_od0, b); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            tick(($urandom() % 4) != 0, {$urandom(), $urandom()}, ($urandom() % 3) != 0,
                 ($urandom() % 8) == 0, ($urandom() % 32) == 0);
            checks++; if (a_ir1 !== e_ir1 || a_ov1 !== e_ov1 || a_od1 !== e_od1) begin errors++; $display("FAIL rand_skid[%0d]: got r=%b v=%b %h want r=%b v=%b %h", k, a_ir1, a_ov1, a_od1, e_ir1, e_ov1, e_od1); end
            checks++; if (a_ir0 !== e_ir0 || a_ov0 !== e_ov0 || a_od0 !== e_od0) begin errors++; $display("FAIL rand_noskid[%0d]: got r=%b v=%b %h want r=%b v=%b %h", k, a_ir0, a_ov0, a_od0, e_ir0, e_ov0, e_od0); end
            checks++; if (p_occ1 !== 2'(x_occ1) || p_occ0 !== 2'(x_occ0)) begin errors++; $display("FAIL rand_occ[%0d]: got %0d/%0d want %0d/%0d", k, p_occ1, p_occ0, x_occ1, x_occ0); end
            checks++; if (p_ov1 !== x_ov1 || p_od1 !== x_od1 || p_ov0 !== x_ov0 || p_od0 !== x_od0) begin errors++; $display("FAIL rand_post[%0d]: got %b %h / %b %h want %b %h / %b %h", k, p_ov1, p_od1, p_ov0, p_od0, x_ov1, x_od1, x_ov0, x_od0); end
            checks++; if (p_cnt1 !== 8'(x_cnt) || p_cnt0 !== 8'(x_cnt)) begin errors++; $display("FAIL rand_flush_cnt[%0d]: got %0d/%0d want %0d", k, p_cnt1, p_cnt0, x_cnt); end
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, {$urandom(), $urandom()}, 1'b0, 1'b0, 1'b0);
        tick(1'b1, {$urandom(), $urandom()}, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        rst = 1'b0; #1;
        checks++; if (dn1.valid !== 1'b0 || occ1 !== 2'd0 || dn1.data !== '0) begin errors++; $display("FAIL async_reset: got v=%b occ=%0d %h want 0 0 0", dn1.valid, occ1, dn1.data); end
        checks++; if (cnt1 !== 8'd0 || occ0 !== 2'd0) begin errors++; $display("FAIL async_reset_cnt: got cnt=%0d occ0=%0d want 0 0", cnt1, occ0); end
        @(negedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_flush();
        int c0;
        tick(1'b1, {$urandom(), $urandom()}, 1'b0, 1'b0, 1'b0);
        tick(1'b1, {$urandom(), $urandom()}, 1'b0, 1'b0, 1'b0);
        checks++; if (p_occ1 !== 2'd2) begin errors++; $display("FAIL flush_setup_occ: got %0d want 2", p_occ1); end
        c0 = x_cnt;
        tick(1'b1, {$urandom(), $urandom()}, 1'b0, 1'b0, 1'b1);
        checks++; if (p_occ1 !== 2'd0 || p_ov1 !== 1'b0) begin errors++; $display("FAIL flush_empty: got occ=%0d v=%b want 0 0", p_occ1, p_ov1); end
        checks++; if (p_od1 !== '0) begin errors++; $display("FAIL flush_rst_val: got %h want 0", p_od1); end
        checks++; if (p_cnt1 !== 8'(c0 + 1)) begin errors++; $display("FAIL flush_cnt_one: got %0d want %0d", p_cnt1, c0 + 1); end
        tick(1'b1, {$urandom(), $urandom()}, 1'b0, 1'b0, 1'b0);
        tick(1'b1, {$urandom(), $urandom()}, 1'b0, 1'b1, 1'b1);
        checks++; if (p_occ1 !== 2'd0 || p_occ0 !== 2'd0) begin errors++; $display("FAIL flush_over_hold: got %0d/%0d want 0/0", p_occ1, p_occ0); end
        checks++; if (p_cnt1 !== 8'(x_cnt)) begin errors++; $display("FAIL flush_over_hold_cnt: got %0d want %0d", p_cnt1, x_cnt); end
        repeat (300) tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
        checks++; if (p_cnt1 !== 8'hFF || p_cnt0 !== 8'hFF) begin errors++; $display("FAIL flush_saturate: got %0d/%0d want 255", p_cnt1, p_cnt0); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_hold();
        test_noskid();
        test_random();
        test_async_reset();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
